uart_tx_param: RTL and testbench

//  Parametrised UART transmitter, the successor to the fixed 8N1 uart_tx.

---
 rtl/uart_tx_param.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_tx_param.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter, LSB first, optional parity, 1 or 2 stop bits.
// Define UART_TX_FIFO_EN to queue FIFO_DEPTH words in front of the FSM for back-to-back frames.
module uart_tx_param #(
   parameter int CLK_DIV    = 10414,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 tx_start,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_ready,
   output logic                 tx_busy,
   output logic                 tx_done,
   output logic                 TxD
);

   localparam int CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] BAUD_PRE  = CW'(CLK_DIV - 2);
   localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

   if (CLK_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
       STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
      $error("uart_tx_param: illegal parameter value");
   end

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        baud_q, baud_d;
   logic [3:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 txd_q, txd_d;
   logic                 done_q, done_d;
   logic                 busy_q, busy_d;
   logic                 bit_end, load, pop, accept, word_avail;
   logic [DATA_BITS-1:0] word_data;

   function automatic logic parity_of(input logic [DATA_BITS-1:0] w);
      return (PARITY == 1) ? ~(^w) : (^w);
   endfunction

`ifdef UART_TX_FIFO_EN
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [AW:0]          wr_q, wr_d, rd_q, rd_d;
   logic                 fifo_full, fifo_empty;

   // Pointers carry one extra wrap bit to tell full from empty.
   assign fifo_empty = (wr_q == rd_q);
   assign fifo_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign tx_ready   = !fifo_full;
   assign accept     = tx_start && tx_ready;
   assign word_avail = !fifo_empty;
   assign word_data  = mem_q[rd_q[AW-1:0]];

   always_comb begin
      wr_d = accept ? wr_q + (AW+1)'(1) : wr_q;
      rd_d = pop    ? rd_q + (AW+1)'(1) : rd_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) mem_q[wr_q[AW-1:0]] <= tx_data;
   end
`else
   logic [DATA_BITS-1:0] hold_q, hold_d;
   logic                 hold_vld_q, hold_vld_d;

   // The held word is handed to the FSM on the next edge, so the block is busy while it waits.
   assign tx_ready   = (state_q == S_IDLE) && !hold_vld_q;
   assign accept     = tx_start && tx_ready;
   assign word_avail = hold_vld_q;
   assign word_data  = hold_q;

   always_comb begin
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      if (accept) begin
         hold_d     = tx_data;
         hold_vld_d = 1'b1;
      end else if (pop) begin
         hold_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
      end else begin
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
      end
   end
`endif

   assign bit_end = (baud_q == BAUD_LAST);

   always_comb begin
      state_d = state_q;
      baud_d  = bit_end ? '0 : baud_q + CW'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      txd_d   = txd_q;
      done_d  = 1'b0;
      load    = 1'b0;
      pop     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            baud_d = '0;
            txd_d  = 1'b1;
            load   = word_avail;
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               txd_d   = shift_q[0];
               shift_d = shift_q >> 1;
               bit_d   = '0;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (bit_q == DATA_LAST) begin
                  bit_d = '0;
                  if (PARITY != 0) begin
                     state_d = S_PARITY;
                     txd_d   = par_q;
                  end else begin
                     state_d = S_STOP;
                     txd_d   = 1'b1;
                  end
               end else begin
                  bit_d   = bit_q + 4'd1;
                  txd_d   = shift_q[0];
                  shift_d = shift_q >> 1;
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP;
               txd_d   = 1'b1;
            end
         end
         S_STOP: begin
            // Registered, so the pulse lands on the final cycle of the last stop bit.
            if (bit_q == STOP_LAST && baud_q == BAUD_PRE) done_d = 1'b1;
            if (bit_end) begin
               if (bit_q != STOP_LAST) begin
                  bit_d = bit_q + 4'd1;
               end else if (word_avail) begin
                  load = 1'b1;
               end else begin
                  state_d = S_IDLE;
                  txd_d   = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            txd_d   = 1'b1;
         end
      endcase
      if (load) begin
         pop     = 1'b1;
         state_d = S_START;
         baud_d  = '0;
         bit_d   = '0;
         shift_d = word_data;
         par_d   = parity_of(word_data);
         txd_d   = 1'b0;
      end
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         txd_q   <= 1'b1;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         txd_q   <= txd_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign TxD     = txd_q;
   assign tx_done = done_q;
   assign tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: drives four uart_tx_param configurations (8N1, 8E1, 8O1, 7N2 at CLK_DIV = 16)
// and compares TxD, tx_done, tx_busy and tx_ready against a bit-list model of each frame.
`timescale 1ns/1ps
module tb_uart_tx_param;

   localparam int NI = 4;
   localparam int D  = 16;

   int db_t  [NI] = '{8, 8, 8, 7};
   int par_t [NI] = '{0, 2, 1, 0};
   int sb_t  [NI] = '{1, 1, 1, 2};

   logic          clk = 1'b0;
   logic          reset_n;
   logic [NI-1:0] start_v;
   logic [8:0]    data_v [NI];
   wire  [NI-1:0] ready_v, busy_v, done_v, txd_v;

   logic [0:0] exp_q[$];
   int         done_at_q[$];
   int         n_checks = 0;
   int         n_pass   = 0;

   always #5 clk = ~clk;

   uart_tx_param #(.CLK_DIV(D), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
      .clk(clk), .reset_n(reset_n), .tx_start(start_v[0]), .tx_data(data_v[0][7:0]),
      .tx_ready(ready_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]), .TxD(txd_v[0]));

   uart_tx_param #(.CLK_DIV(D), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
      .clk(clk), .reset_n(reset_n), .tx_start(start_v[1]), .tx_data(data_v[1][7:0]),
      .tx_ready(ready_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]), .TxD(txd_v[1]));

   uart_tx_param #(.CLK_DIV(D), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
      .clk(clk), .reset_n(reset_n), .tx_start(start_v[2]), .tx_data(data_v[2][7:0]),
      .tx_ready(ready_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]), .TxD(txd_v[2]));

   uart_tx_param #(.CLK_DIV(D), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7n2 (
      .clk(clk), .reset_n(reset_n), .tx_start(start_v[3]), .tx_data(data_v[3][6:0]),
      .tx_ready(ready_v[3]), .tx_busy(busy_v[3]), .tx_done(done_v[3]), .TxD(txd_v[3]));

   // Appends one frame as a list of line levels, one entry per bit time, and notes its final cycle.
   task automatic model_frame(input int idx, input logic [8:0] w);
      int ones;
      ones = 0;
      exp_q.push_back(1'b0);
      for (int i = 0; i < db_t[idx]; i++) begin
         exp_q.push_back(w[i]);
         ones += int'(w[i]);
      end
      if (par_t[idx] == 2) exp_q.push_back(1'(ones % 2));
      else if (par_t[idx] == 1) exp_q.push_back(1'((ones + 1) % 2));
      for (int i = 0; i < sb_t[idx]; i++) exp_q.push_back(1'b1);
      done_at_q.push_back(exp_q.size() * D - 1);
   endtask

   task automatic send(input int idx, input logic [8:0] w, input bit hold);
      int waited;
      waited = 0;
      @(negedge clk);
      while (ready_v[idx] !== 1'b1 && waited < 4 * D) begin
         @(negedge clk);
         waited++;
      end
      n_checks++;
      if (ready_v[idx] !== 1'b1)
         $display("FAIL ready_wait[%0d]: tx_ready=%b after %0d cycles, want 1", idx, ready_v[idx], waited);
      else n_pass++;
      start_v[idx] = 1'b1;
      data_v[idx]  = w;
      @(posedge clk);
      #1;
      if (hold) begin
         data_v[idx] = 9'h012;
      end else begin
         start_v[idx] = 1'b0;
         data_v[idx]  = 9'($urandom);
      end
   endtask

   // Starts just after the accepting edge; walks every cycle of the modelled frames, then idle time.
   task automatic observe(input int idx, input string tag, input bit hold);
      int   ncyc, dp, txd_err, first_c, done_err, busy_err, ready_err, idle_err;
      logic got_b, want_b, exp_done;
      ncyc = exp_q.size() * D;
      dp = 0; txd_err = 0; first_c = -1; done_err = 0; busy_err = 0; ready_err = 0; idle_err = 0;
      got_b = 1'b0; want_b = 1'b0;
      @(negedge clk);
      n_checks++;
      if (txd_v[idx] !== 1'b1)
         $display("FAIL %s latency: TxD=%b in the cycle after acceptance, want 1", tag, txd_v[idx]);
      else n_pass++;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         if (txd_v[idx] !== exp_q[c / D]) begin
            if (txd_err == 0) begin
               first_c = c;
               got_b   = txd_v[idx];
               want_b  = exp_q[c / D];
            end
            txd_err++;
         end
         exp_done = (dp < done_at_q.size()) && (done_at_q[dp] == c);
         if (exp_done) dp++;
         if (done_v[idx] !== exp_done) done_err++;
         if (busy_v[idx] !== 1'b1) busy_err++;
         if (ready_v[idx] !== 1'b0) ready_err++;
      end
      n_checks++;
      if (txd_err != 0)
         $display("FAIL %s txd: %0d bad cycles, first at cycle %0d got %b want %b", tag, txd_err, first_c, got_b, want_b);
      else n_pass++;
      n_checks++;
      if (done_err != 0 || dp != done_at_q.size())
         $display("FAIL %s tx_done: %0d bad cycles, %0d pulses seen at expected cycles, want %0d", tag, done_err, dp, done_at_q.size());
      else n_pass++;
      n_checks++;
      if (busy_err != 0)
         $display("FAIL %s tx_busy: low in %0d of %0d frame cycles, want 0", tag, busy_err, ncyc);
      else n_pass++;
      if (hold) begin
         n_checks++;
         if (ready_err != 0)
            $display("FAIL %s tx_ready: high in %0d frame cycles, want 0", tag, ready_err);
         else n_pass++;
         @(posedge clk);
         #1;
         start_v[idx] = 1'b0;
      end
      for (int c = 0; c < 2 * D; c++) begin
         @(negedge clk);
         if (txd_v[idx] !== 1'b1 || busy_v[idx] !== 1'b0 || done_v[idx] !== 1'b0) idle_err++;
      end
      n_checks++;
      if (idle_err != 0)
         $display("FAIL %s idle_after: %0d cycles not idle (TxD=1 busy=0 done=0), want 0", tag, idle_err);
      else n_pass++;
   endtask

   task automatic run_frame(input int idx, input logic [8:0] w, input string tag);
      exp_q.delete();
      done_at_q.delete();
      model_frame(idx, w);
      send(idx, w, 1'b0);
      observe(idx, tag, 1'b0);
   endtask

   task automatic test_reset();
      start_v = '0;
      for (int i = 0; i < NI; i++) data_v[i] = '0;
      reset_n = 1'b1;
      #2 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         n_checks++;
         if ({txd_v[i], busy_v[i], done_v[i]} !== 3'b100)
            $display("FAIL reset_state[%0d]: TxD,busy,done=%b want 100", i, {txd_v[i], busy_v[i], done_v[i]});
         else n_pass++;
      end
      reset_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (ready_v !== 4'b1111) $display("FAIL reset_ready: tx_ready=%b want 1111", ready_v);
      else n_pass++;
   endtask

   task automatic test_fixed_vectors();
      run_frame(0, 9'h0AB, "8n1_AB");
      run_frame(1, 9'h0CD, "even_CD");
      run_frame(2, 9'h0CD, "odd_CD");
      run_frame(3, 9'h055, "7n2_55");
   endtask

   task automatic test_random_words();
      logic [8:0] w;
      for (int i = 0; i < NI; i++) begin
         for (int n = 0; n < 3; n++) begin
            w = 9'($urandom_range(0, (1 << db_t[i]) - 1));
            run_frame(i, w, $sformatf("rand%0d_%0d", i, n));
         end
      end
   endtask

`ifndef UART_TX_FIFO_EN
   task automatic test_ignore_while_busy();
      exp_q.delete();
      done_at_q.delete();
      model_frame(0, 9'h0A5);
      send(0, 9'h0A5, 1'b1);
      observe(0, "hold_start", 1'b1);
   endtask
`else
   task automatic test_fifo_burst();
      exp_q.delete();
      done_at_q.delete();
      for (int i = 1; i <= 5; i++) model_frame(0, 9'(i));
      @(negedge clk);
      fork
         begin
            for (int i = 1; i <= 5; i++) begin
               n_checks++;
               if (ready_v[0] !== 1'b1) $display("FAIL fifo_push%0d: tx_ready=%b want 1", i, ready_v[0]);
               else n_pass++;
               start_v[0] = 1'b1;
               data_v[0]  = 9'(i);
               @(posedge clk);
               #1;
               if (i < 5) @(negedge clk);
            end
            start_v[0] = 1'b0;
            n_checks++;
            if (ready_v[0] !== 1'b0) $display("FAIL fifo_full: tx_ready=%b with 4 queued, want 0", ready_v[0]);
            else n_pass++;
         end
         begin
            @(posedge clk);
            #1;
            observe(0, "fifo_burst", 1'b0);
         end
      join
   endtask
`endif

   task automatic test_reset_mid_frame();
      exp_q.delete();
      done_at_q.delete();
      model_frame(0, 9'h0F0);
      send(0, 9'h0F0, 1'b0);
      @(negedge clk);
      repeat (3 * D + 5) @(negedge clk);
      n_checks++;
      if (txd_v[0] !== exp_q[(3 * D + 4) / D])
         $display("FAIL mid_frame_bit: TxD=%b before reset, want %b", txd_v[0], exp_q[(3 * D + 4) / D]);
      else n_pass++;
      reset_n = 1'b0;
      #1;
      n_checks++;
      if ({txd_v[0], busy_v[0], done_v[0]} !== 3'b100)
         $display("FAIL async_reset: TxD,busy,done=%b want 100", {txd_v[0], busy_v[0], done_v[0]});
      else n_pass++;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({ready_v[0], txd_v[0], busy_v[0]} !== 3'b110)
         $display("FAIL after_reset: ready,TxD,busy=%b want 110", {ready_v[0], txd_v[0], busy_v[0]});
      else n_pass++;
      run_frame(0, 9'h03C, "post_reset_3C");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("%0d/%0d checks passed", n_pass, n_checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_fixed_vectors();
      test_random_words();
`ifndef UART_TX_FIFO_EN
      test_ignore_while_busy();
`else
      test_fifo_burst();
`endif
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
